issue_execute_fifo: RTL and testbench

ISSUE_EXECUTE_FIFO -- requirements
Module: issue_execute_fifo

---
 rtl/issue_execute_fifo_if.sv | 34 +++
 rtl/issue_execute_fifo.sv | 74 +++++++
 tb/tb_issue_execute_fifo.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/issue_execute_fifo_if.sv
// Issue/execute FIFO handshake bundle plus the packed issue payload type.
// The FIFO takes the slave view, the issuing/executing side the master view.
package issue_execute_fifo_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [19:0] imm;
  } issue_execute_pack_t;
endpackage

interface issue_execute_fifo_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = $bits(issue_execute_fifo_pkg::issue_execute_pack_t)
);
  logic                     push;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     flush;
  logic                     full;
  logic                     full_add;
  logic                     pop;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_out_valid;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output push, data_in, flush, pop,
    input  full, full_add, data_out, data_out_valid, count
  );

  modport slave (
    input  push, data_in, flush, pop,
    output full, full_add, data_out, data_out_valid, count
  );
endinterface

// File: rtl/issue_execute_fifo.sv
// Issue-to-execute FIFO; push-to-valid latency 1 cycle (0 with ISSUE_EXECUTE_FIFO_BYPASS_EN into an empty FIFO).
// Backpressure: full from registered occupancy; pushes while full are dropped and flagged on full_add.
module issue_execute_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = $bits(issue_execute_fifo_pkg::issue_execute_pack_t)
) (
  input logic                 clk,
  input logic                 rst,
  issue_execute_fifo_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  full_w;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  bypass_take;
  logic                  wr_en;
  logic                  rd_en;
  logic                  out_vld;
  logic [DATA_WIDTH-1:0] out_dat;

  assign full_w   = (count_q == FULL_CNT);
  assign push_acc = io.push & ~full_w & ~io.flush;
  assign pop_acc  = io.pop & out_vld & ~io.flush;

`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
  logic bypass;
  // Gated by rst so the forwarded entry cannot show up while in reset.
  assign bypass      = rst & (count_q == '0) & io.push & ~io.flush;
  assign out_vld     = (count_q != '0) | bypass;
  assign out_dat     = bypass ? io.data_in : mem[rd_ptr];
  assign bypass_take = bypass & io.pop;
`else
  assign out_vld     = (count_q != '0);
  assign out_dat     = mem[rd_ptr];
  assign bypass_take = 1'b0;
`endif

  // An entry forwarded and consumed in the same cycle never touches storage.
  assign wr_en = push_acc & ~bypass_take;
  assign rd_en = pop_acc & ~bypass_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (io.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= io.data_in;
  end

  assign io.full           = full_w;
  assign io.full_add       = io.push & full_w;
  assign io.count          = count_q;
  assign io.data_out       = out_dat;
  assign io.data_out_valid = out_vld;
endmodule

// File: tb/tb_issue_execute_fifo.sv
// Directed table-driven bench for issue_execute_fifo (DEPTH=8, 32-bit payload),
// plus hand sequences for async reset mid-stream and push+pop into an empty FIFO.
module tb_issue_execute_fifo;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  typedef struct {
    logic          push;
    logic          pop;
    logic          flush;
    logic [DW-1:0] din;
    int            exp_count;
    logic          exp_full;
    logic          exp_fa;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          chk_out;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];

  issue_execute_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) io ();

  issue_execute_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic push, input logic pop, input logic flush,
                              input logic [DW-1:0] din, input int cnt, input logic full,
                              input logic fa, input logic vld, input logic [DW-1:0] dat,
                              input logic chk_out);
    vec_t v;
    v.push = push; v.pop = pop; v.flush = flush; v.din = din;
    v.exp_count = cnt; v.exp_full = full; v.exp_fa = fa;
    v.exp_valid = vld; v.exp_data = dat; v.chk_out = chk_out;
    return v;
  endfunction

  task automatic drive(input logic push, input logic pop, input logic flush, input logic [DW-1:0] din);
    io.push = push; io.pop = pop; io.flush = flush; io.data_in = din;
  endtask

  // Drive just after the rising edge, check on the falling edge of the same cycle.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    drive(v.push, v.pop, v.flush, v.din);
    @(negedge clk);
    chk({tag, ".count"}, DW'(io.count), DW'(v.exp_count));
    chk({tag, ".full"}, DW'(io.full), DW'(v.exp_full));
    chk({tag, ".full_add"}, DW'(io.full_add), DW'(v.exp_fa));
    if (v.chk_out) begin
      chk({tag, ".valid"}, DW'(io.data_out_valid), DW'(v.exp_valid));
      if (v.exp_valid) chk({tag, ".data"}, io.data_out, v.exp_data);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);

    // Fill to full, overflow attempts, drain in order.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 2; k <= 8; k++) tbl.push_back(mk(1, 0, 0, DW'(k), k - 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 9, 8, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 'h99, 8, 1, 1, 1, 1, 1));
    for (int j = 2; j <= 8; j++) tbl.push_back(mk(0, 1, 0, 0, 9 - j, 0, 0, 1, DW'(j), 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Hold four entries and stream through the pointer wrap.
    tbl.push_back(mk(1, 0, 0, 'h10, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) tbl.push_back(mk(1, 0, 0, DW'('h10 + k), k, 0, 0, 1, 'h10, 1));
    for (int i = 0; i < 20; i++) tbl.push_back(mk(1, 1, 0, DW'('h14 + i), 4, 0, 0, 1, DW'('h10 + i), 1));
    // Flush beats a simultaneous push and pop at count 5.
    tbl.push_back(mk(1, 0, 0, 'h28, 4, 0, 0, 1, 'h24, 1));
    tbl.push_back(mk(1, 1, 1, 'h29, 5, 0, 0, 1, 'h24, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Values held in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.count", DW'(io.count), 0);
    chk("rst.full", DW'(io.full), 0);
    chk("rst.valid", DW'(io.data_out_valid), 0);
    chk("rst.full_add", DW'(io.full_add), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // Asynchronous reset with three entries resident.
    apply(mk(1, 0, 0, 'h30, 0, 0, 0, 0, 0, 0), "ar0");
    apply(mk(1, 0, 0, 'h31, 1, 0, 0, 1, 'h30, 1), "ar1");
    apply(mk(1, 0, 0, 'h32, 2, 0, 0, 1, 'h30, 1), "ar2");
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("ar.pre_count", DW'(io.count), 3);
    rst = 1'b0;
    #1;
    chk("ar.count", DW'(io.count), 0);
    chk("ar.valid", DW'(io.data_out_valid), 0);
    chk("ar.full", DW'(io.full), 0);
    chk("ar.full_add", DW'(io.full_add), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    apply(mk(1, 0, 0, 'hA, 0, 0, 0, 0, 0, 0), "ar3");
    apply(mk(0, 0, 0, 0, 1, 0, 0, 1, 'hA, 1), "ar4");
    apply(mk(0, 1, 0, 0, 1, 0, 0, 1, 'hA, 1), "ar5");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ar6");

    // Push with same-cycle pop into an empty FIFO.
    @(posedge clk);
    #1 drive(1'b1, 1'b1, 1'b0, 'hB);
    #1;
`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
    chk("byp.valid", DW'(io.data_out_valid), 1);
    chk("byp.data", io.data_out, 'hB);
    chk("byp.count", DW'(io.count), 0);
`else
    chk("byp.valid", DW'(io.data_out_valid), 0);
    chk("byp.count", DW'(io.count), 0);
`endif
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, '0);
    #1;
`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
    chk("byp.next_count", DW'(io.count), 0);
    chk("byp.next_valid", DW'(io.data_out_valid), 0);
`else
    chk("byp.next_count", DW'(io.count), 1);
    chk("byp.next_valid", DW'(io.data_out_valid), 1);
    chk("byp.next_data", io.data_out, 'hB);
    apply(mk(0, 1, 0, 0, 1, 0, 0, 1, 'hB, 1), "byp.drain");
`endif
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "byp.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
